// File: rtl/keyb_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : keyb_emulator
//  Purpose  : Behavioural 4x4 keypad model. Watches the one-hot column strobe
//             from the keypad scanner and drives the row lines as a physical
//             keypad with a single pressed key would. A host queues one key
//             code at a time over a valid/ready handshake; the key is held for
//             HOLD_FRAMES scan frames, then released for GAP_FRAMES frames.
//  Ports    : clk, reset       - clock and synchronous active-high reset
//             cols[3:0]        - one-hot column strobe from the scanner
//             rows[3:0]        - row lines back to the scanner (combinational)
//             key_valid        - host offers key_code
//             key_code[7:0]    - [7:4] one-hot column, [3:0] one-hot row
//             key_ready        - block can accept a code
//             busy             - press or release gap in progress
//             code_err         - one-cycle pulse after an illegal code offer
//             press_count[7:0] - completed presses, wraps modulo 256
//  Revision : 1.0 - initial release
// ============================================================================
module keyb_emulator #(
    parameter int HOLD_FRAMES = 3,
    parameter int GAP_FRAMES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    output logic       key_ready,
    output logic       busy,
    output logic       code_err,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_PRESS = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [7:0] c_HOLD_LAST = 8'(HOLD_FRAMES - 1);
    localparam logic [7:0] c_GAP_LAST  = 8'(GAP_FRAMES - 1);

    state_t     r_state_q, w_state_d;
    logic [7:0] r_key_q,   w_key_d;
    logic [7:0] r_frame_q, w_frame_d;
    logic [7:0] r_count_q, w_count_d;
    logic       r_ready_q, w_ready_d;
    logic       r_busy_q,  w_busy_d;
    logic       r_err_q,   w_err_d;
    logic       w_frame_end;
    logic [3:0] w_rows;

    function automatic logic f_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Column 1000 is the last strobe of a frame; illegal strobes never match.
    assign w_frame_end = (cols == 4'b1000);

    always_comb begin
        w_state_d = r_state_q;
        w_key_d   = r_key_q;
        w_frame_d = r_frame_q;
        w_count_d = r_count_q;
        w_err_d   = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (key_valid && r_ready_q) begin
                    if (f_onehot4(key_code[7:4]) && f_onehot4(key_code[3:0])) begin
                        w_key_d   = key_code;
                        w_state_d = ST_SYNC;
                    end else begin
                        w_err_d = 1'b1;
                    end
                end
            end
            ST_SYNC: begin
                // Entering PRESS on a frame end makes the press begin on
                // column 0001 of a fresh frame.
                if (w_frame_end) begin
                    w_state_d = ST_PRESS;
                    w_frame_d = 8'd0;
                end
            end
            ST_PRESS: begin
                if (w_frame_end) begin
                    if (r_frame_q == c_HOLD_LAST) begin
                        w_state_d = ST_GAP;
                        w_frame_d = 8'd0;
                        w_count_d = r_count_q + 8'd1;
                    end else begin
                        w_frame_d = r_frame_q + 8'd1;
                    end
                end
            end
            ST_GAP: begin
                if (w_frame_end) begin
                    if (r_frame_q == c_GAP_LAST) begin
                        w_state_d = ST_IDLE;
                        w_frame_d = 8'd0;
                    end else begin
                        w_frame_d = r_frame_q + 8'd1;
                    end
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
        // Handshake outputs are registered copies of the next state.
        w_ready_d = (w_state_d == ST_IDLE);
        w_busy_d  = (w_state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= ST_IDLE;
            r_key_q   <= 8'd0;
            r_frame_q <= 8'd0;
            r_count_q <= 8'd0;
            r_ready_q <= 1'b1;
            r_busy_q  <= 1'b0;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_key_q   <= w_key_d;
            r_frame_q <= w_frame_d;
            r_count_q <= w_count_d;
            r_ready_q <= w_ready_d;
            r_busy_q  <= w_busy_d;
            r_err_q   <= w_err_d;
        end
    end

    // Rows follow the live strobe so the scanner sees them in the same cycle.
    always_comb begin
        w_rows = 4'b0000;
        if ((r_state_q == ST_PRESS) && (cols == r_key_q[7:4])) begin
            w_rows = r_key_q[3:0];
        end
    end

    assign rows        = w_rows;
    assign key_ready   = r_ready_q;
    assign busy        = r_busy_q;
    assign code_err    = r_err_q;
    assign press_count = r_count_q;

endmodule
`default_nettype wire

// File: tb/tb_keyb_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keyb_emulator
//  Purpose  : Directed self-checking bench for keyb_emulator. A free-running
//             column scanner model drives cols and can be stalled to 0000.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keyb_emulator;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cols = 4'b0000;
    logic [3:0] rows;
    logic       key_valid = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       key_ready;
    logic       busy;
    logic       code_err;
    logic [7:0] press_count;

    logic [1:0] r_phase = 2'd0;
    logic       scan_stall = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    keyb_emulator #(.HOLD_FRAMES(3), .GAP_FRAMES(2)) dut (
        .clk(clk), .reset(reset), .cols(cols), .rows(rows),
        .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
        .busy(busy), .code_err(code_err), .press_count(press_count)
    );

    always #5 clk = ~clk;

    // Scanner model: steps one column per cycle; a stall drives 0000 and
    // freezes the scan position.
    always @(posedge clk) begin
        if (scan_stall) begin
            cols <= 4'b0000;
        end else begin
            cols    <= 4'b0001 << r_phase;
            r_phase <= r_phase + 2'd1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs until key_ready returns, tracking every cycle with rows driven.
    task automatic run_until_ready(input logic [7:0] code, output int rows_cyc,
                                   output int bad, output int first,
                                   output int ready_at, output bit tmo);
        rows_cyc = 0; bad = 0; first = -1; ready_at = -1; tmo = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (rows !== 4'b0000) begin
                rows_cyc++;
                if (first < 0) first = cyc;
                if ({cols, rows} !== code) bad++;
            end
            if (key_ready === 1'b1) begin
                ready_at = cyc;
                tmo      = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_rows(output bit found);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (rows !== 4'b0000) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int rc, bad, first, rdy, zeros, tmo_cnt, bad_sum;
        bit tmo, found;

        // Reset while the scanner is running
        reset = 1'b1;
        tick(); tick();
        check("reset_rows", rows, 4'b0000);
        check("reset_ready", key_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_err", code_err, 1'b0);
        check("reset_count", press_count, 8'd0);
        reset = 1'b0;
        tick();

        // Closed loop, key 0x21: rows 0001 on column 0010 for 3 frames
        key_valid = 1'b1; key_code = 8'h21;
        tick();
        key_valid = 1'b0;
        check("accept_ready_low", key_ready, 1'b0);
        check("accept_busy_high", busy, 1'b1);
        run_until_ready(8'h21, rc, bad, first, rdy, tmo);
        check("k21_timeout", tmo, 1'b0);
        check("k21_row_cycles", rc, 3);
        check("k21_wrong_code", bad, 0);
        // First row cycle is one after press start; ready returns 20 after start
        check("k21_ready_latency", rdy - first, 19);
        check("k21_count", press_count, 8'd1);
        check("k21_busy_low", busy, 1'b0);

        // Back-to-back: valid held high, code changes while busy
        key_valid = 1'b1; key_code = 8'h18;
        tick();
        key_code = 8'h84;
        check("b2b_first_ready", key_ready, 1'b0);
        run_until_ready(8'h18, rc, bad, first, rdy, tmo);
        check("b2b_first_timeout", tmo, 1'b0);
        check("b2b_first_rows", rc, 3);
        check("b2b_first_code", bad, 0);
        tick();
        key_valid = 1'b0;
        check("b2b_second_accept", key_ready, 1'b0);
        run_until_ready(8'h84, rc, bad, first, rdy, tmo);
        check("b2b_second_timeout", tmo, 1'b0);
        check("b2b_second_rows", rc, 3);
        check("b2b_second_code", bad, 0);
        check("b2b_count", press_count, 8'd3);

        // Illegal codes
        key_valid = 1'b1; key_code = 8'h33;
        tick();
        key_valid = 1'b0;
        check("ill33_err", code_err, 1'b1);
        check("ill33_ready", key_ready, 1'b1);
        check("ill33_busy", busy, 1'b0);
        tick();
        check("ill33_err_clear", code_err, 1'b0);
        key_valid = 1'b1; key_code = 8'h01;
        tick();
        key_valid = 1'b0;
        check("ill01_err", code_err, 1'b1);
        tick();
        check("ill01_err_clear", code_err, 1'b0);
        zeros = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rows !== 4'b0000 || key_ready !== 1'b1) zeros++;
        end
        check("ill_stays_idle", zeros, 0);

        // Reset during the second press frame of 0x42
        key_valid = 1'b1; key_code = 8'h42;
        tick();
        key_valid = 1'b0;
        wait_rows(found);
        check("k42_frame1", found, 1'b1);
        check("k42_frame1_rows", rows, 4'b0010);
        tick();
        wait_rows(found);
        check("k42_frame2", found, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_rows", rows, 4'b0000);
        check("midrst_ready", key_ready, 1'b1);
        check("midrst_count", press_count, 8'd0);
        zeros = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rows !== 4'b0000) zeros++;
        end
        check("midrst_rows_quiet", zeros, 0);

        // Press with the strobe stalled at 0000 for 5 cycles
        key_valid = 1'b1; key_code = 8'h21;
        tick();
        key_valid = 1'b0;
        wait_rows(found);
        check("stall_first_row", found, 1'b1);
        first = cyc;
        scan_stall = 1'b1;
        zeros = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (cols !== 4'b0000 || rows !== 4'b0000) zeros++;
        end
        scan_stall = 1'b0;
        check("stall_rows_zero", zeros, 0);
        run_until_ready(8'h21, rc, bad, zeros, rdy, tmo);
        check("stall_timeout", tmo, 1'b0);
        check("stall_rows_left", rc, 2);
        check("stall_code", bad, 0);
        check("stall_latency", rdy - first, 24);
        check("stall_count", press_count, 8'd1);

        // Remaining presses to reach the wrap
        tmo_cnt = 0; bad_sum = 0;
        key_valid = 1'b1; key_code = 8'h21;
        for (int i = 0; i < 254; i++) begin
            tick();
            run_until_ready(8'h21, rc, bad, first, rdy, tmo);
            if (tmo) tmo_cnt++;
            if (rc != 3) bad_sum++;
            bad_sum += bad;
        end
        check("wrap_loop_timeout", tmo_cnt, 0);
        check("wrap_loop_rows", bad_sum, 0);
        check("count_255", press_count, 8'd255);
        tick();
        key_valid = 1'b0;
        run_until_ready(8'h21, rc, bad, first, rdy, tmo);
        check("wrap_last_timeout", tmo, 1'b0);
        check("count_wrap", press_count, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keyb_emulator.md
# keyb_emulator

Behavioural keypad model for the 4x4 matrix interface: it watches the one-hot column strobe driven by the keypad scanner and drives the row lines as a physical keypad with one pressed key would. A host or test sequencer queues one key code at a time through a valid/ready handshake. The block holds the key for a programmable number of scan frames, then releases it for a programmable gap. It sits on the far side of the `cols`/`rows` pins, in place of the keypad, for board bring-up and closed-loop simulation.

## Interface
- `HOLD_FRAMES`, default 3: full scan frames the key stays pressed; legal range 1..255.
- `GAP_FRAMES`, default 2: full scan frames of release after each press; legal range 1..255.
- `clk` input 1: single clock, shared with the scanner.
- `reset` input 1: synchronous, active-high.
- `cols` input 4: column strobe from the scanner; one-hot, stepping 0001→0010→0100→1000→0001 one step per cycle.
- `rows` output 4: row lines returned to the scanner.
- `key_valid` input 1: the host presents `key_code`.
- `key_code` input 8: [7:4] is the one-hot column and [3:0] is the one-hot row. This is the same encoding the scanner reports.
- `key_ready` output 1: the block can accept a code.
- `busy` output 1: a press or gap is in progress.
- `code_err` output 1: one-cycle pulse when an illegal code is offered.
- `press_count` output 8: number of completed presses, wraps modulo 256.

## Operation
- FSM states: IDLE, SYNC, PRESS, GAP.
- IDLE:
  - `key_ready`=1 and `busy`=0.
  - A transfer occurs on a cycle where `key_valid` && `key_ready`.
  - If the code is legal (each nibble has exactly one bit set), latch the code into `key_reg` and go to SYNC.
  - If the code is illegal, pulse `code_err` the next cycle, stay in IDLE, and leave `key_reg` unchanged.
- SYNC:
  - Wait for a cycle with `cols`==1000; on that edge go to PRESS and clear the frame counter.
  - This guarantees the press starts on column 0001 of a fresh frame.
- PRESS:
  - `rows` = `key_reg[3:0]` when `cols`==`key_reg[7:4]`, otherwise 0000.
  - The frame counter increments on each cycle with `cols`==1000.
  - On the cycle where `cols`==1000 and the counter equals HOLD_FRAMES-1: go to GAP, clear the counter, and increment `press_count`.
- GAP:
  - `rows`=0000.
  - Count `cols`==1000 cycles in the same way.
  - After GAP_FRAMES frames, return to IDLE.
- `rows` is combinational from the registered state/`key_reg` and the live `cols`, so the scanner samples it in the same cycle as the strobe. No other output is combinational.
- Illegal `cols` value (0000 or more than one bit set): `rows`=0000, and the cycle does not count as a frame end.
- `key_valid` is ignored outside IDLE. Codes are not queued, and `key_code` may change freely while `key_ready`=0.
- `press_count` increments at PRESS→GAP, so an aborted press is not counted.
- Frame counter is 8 bits.

## Timing
- Reset values (registered outputs take these on the reset edge):
  - state IDLE, `key_reg`=0, frame counter 0.
  - `key_ready`=1, `busy`=0, `code_err`=0, `press_count`=0, `rows`=0000.
- Reset mid-operation forces IDLE on that edge, so `rows` is 0000 from the next cycle.
- Accept edge N: `key_ready`=0 and `busy`=1 from cycle N+1.
- The earliest press is visible at the first `cols`==0001 following a `cols`==1000 seen after N.
- PRESS lasts exactly 4·HOLD_FRAMES cycles.
- GAP lasts exactly 4·GAP_FRAMES cycles.
- `key_ready` returns on the cycle after GAP's final frame end.
- `code_err` is high exactly one cycle, at N+1.

## Test plan
- **Reset check:** assert `reset` for 2 cycles while `cols` is scanning.
  - Required: `rows`=0000, `key_ready`=1, `press_count`=0.
- **Closed loop with the scanner:** offer `key_code`=0x21, HOLD_FRAMES=3, GAP_FRAMES=2.
  - Required: `rows`=0001 only while `cols`=0010, for exactly 3 frames.
  - Required: the scanner reports `btn_out`=0x21 with `btn_pressed`=1, then `btn_out`=0x00.
  - Required: `press_count`=1, and `key_ready` returns 20 cycles after the press starts.
- **Back-to-back keys:** hold `key_valid` high with 0x18, then 0x84.
  - Required: the second code is accepted only when `key_ready` returns.
  - Required: no frame with both keys visible; `press_count`=2.
- **Illegal codes:** offer 0x33, then 0x01.
  - Required: `code_err` pulses 1 cycle for each code, the state stays IDLE, and `rows` stays 0000.
- **Reset mid-press:** assert `reset` during the second PRESS frame of 0x42.
  - Required: `rows`=0000 from the next cycle, `press_count` unchanged (0), and `key_ready`=1.
- **Counter wrap and illegal strobe:** run 256 presses, with `cols` forced to 0000 for 5 cycles during one press.
  - Required: `press_count` wraps to 0.
  - Required: the forced-0000 cycles produce `rows`=0000 and do not shorten the press frame count.
